// File: rtl/axis_coef_unpack.sv
// rtl/axis_coef_unpack.sv - unpacks 64-bit stream beats into 32-bit coefficients
// Holds one beat, emits its lower then (if kept) upper half, and tracks packet index, length and format errors.
module axis_coef_unpack #(
  parameter int N_COEF = 20
) (
  input  logic        iSYS_CLK,
  input  logic        iSYS_RST,
  input  logic        iS_AXIS_TVALID,
  output logic        oS_AXIS_TREADY,
  input  logic [63:0] iS_AXIS_TDATA,
  input  logic [7:0]  iS_AXIS_TKEEP,
  input  logic        iS_AXIS_TLAST,
  output logic        oCOEF_VALID,
  input  logic        iCOEF_READY,
  output logic [31:0] oCOEF_DATA,
  output logic        oCOEF_LAST,
  output logic [15:0] oCOEF_IDX,
  output logic        oPKT_DONE,
  output logic        oERR_LEN,
  output logic        oERR_FMT,
  input  logic        iERR_CLR
);

  typedef enum logic [1:0] {EMPTY, EMIT_LO, EMIT_HI} state_t;

  state_t      state;
  state_t      stateNext;
  logic [63:0] holdData;
  logic        holdHiValid;
  logic        holdLast;
  logic [15:0] coefIdx;
  logic [16:0] coefCount;
  logic        pktDone;
  logic        errLen;
  logic        errFmt;
  logic        finalOfBeat;
  logic        beatHs;
  logic        coefHs;
  logic        keepHi;
  logic        keepBad;
  logic        lenBad;

  assign beatHs  = iS_AXIS_TVALID && oS_AXIS_TREADY;
  assign coefHs  = oCOEF_VALID && iCOEF_READY;
  assign keepHi  = |iS_AXIS_TKEEP[7:4];
  assign keepBad = (iS_AXIS_TKEEP != 8'hFF) && (iS_AXIS_TKEEP != 8'h0F);
  // coefCount holds the coefficients already accepted, so the closing one adds 1
  assign lenBad  = (coefCount + 17'd1) != 17'(N_COEF);

  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      EMPTY: begin
        if (beatHs) stateNext = EMIT_LO;
      end
      EMIT_LO: begin
        if (coefHs) begin
          if (holdHiValid)  stateNext = EMIT_HI;
          else if (beatHs)  stateNext = EMIT_LO;
          else              stateNext = EMPTY;
        end
      end
      EMIT_HI: begin
        if (coefHs) stateNext = beatHs ? EMIT_LO : EMPTY;
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_comb begin
    finalOfBeat    = (state == EMIT_HI) || ((state == EMIT_LO) && !holdHiValid);
    oCOEF_VALID    = (state != EMPTY);
    // a new beat may land in the same cycle the held beat's last half leaves
    oS_AXIS_TREADY = !iSYS_RST && ((state == EMPTY) || (finalOfBeat && iCOEF_READY));
    oCOEF_DATA     = (state == EMIT_HI) ? holdData[63:32] : holdData[31:0];
    oCOEF_LAST     = holdLast && finalOfBeat;
    oCOEF_IDX      = coefIdx;
    oPKT_DONE      = pktDone;
    oERR_LEN       = errLen;
    oERR_FMT       = errFmt;
  end

  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      holdData    <= '0;
      holdHiValid <= 1'b0;
      holdLast    <= 1'b0;
    end else if (beatHs) begin
      holdData    <= iS_AXIS_TDATA;
      holdHiValid <= keepHi;
      holdLast    <= iS_AXIS_TLAST;
    end
  end

  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      coefIdx   <= '0;
      coefCount <= '0;
    end else if (coefHs) begin
      if (oCOEF_LAST) begin
        coefIdx   <= '0;
        coefCount <= '0;
      end else begin
        if (coefIdx != 16'hFFFF) coefIdx <= coefIdx + 16'd1;
        if (coefCount != '1)     coefCount <= coefCount + 17'd1;
      end
    end
  end

  // setting an error takes priority over a same-cycle clear
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      pktDone <= 1'b0;
      errLen  <= 1'b0;
      errFmt  <= 1'b0;
    end else begin
      pktDone <= coefHs && oCOEF_LAST;
      if (coefHs && oCOEF_LAST && lenBad) errLen <= 1'b1;
      else if (iERR_CLR)                  errLen <= 1'b0;
      if (beatHs && keepBad)              errFmt <= 1'b1;
      else if (iERR_CLR)                  errFmt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_coef_unpack.sv
// tb/tb_axis_coef_unpack.sv - scoreboard bench for axis_coef_unpack
// A queue model of expected coefficients is compared every cycle; directed packets pin the model with literals.
module tb_axis_coef_unpack;

  localparam int NA = 20;
  localparam int NB = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tvalid, tlast, coefReady, errClr;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  logic        aTready, aValid, aLast, aDone, aErrLen, aErrFmt;
  logic [31:0] aData;
  logic [15:0] aIdx;
  logic        bTready, bValid, bLast, bDone, bErrLen, bErrFmt;
  logic [31:0] bData;
  logic [15:0] bIdx;

  axis_coef_unpack #(.N_COEF(NA)) dutA (
    .iSYS_CLK(clk), .iSYS_RST(rst),
    .iS_AXIS_TVALID(tvalid), .oS_AXIS_TREADY(aTready), .iS_AXIS_TDATA(tdata),
    .iS_AXIS_TKEEP(tkeep), .iS_AXIS_TLAST(tlast),
    .oCOEF_VALID(aValid), .iCOEF_READY(coefReady), .oCOEF_DATA(aData),
    .oCOEF_LAST(aLast), .oCOEF_IDX(aIdx), .oPKT_DONE(aDone),
    .oERR_LEN(aErrLen), .oERR_FMT(aErrFmt), .iERR_CLR(errClr)
  );

  axis_coef_unpack #(.N_COEF(NB)) dutB (
    .iSYS_CLK(clk), .iSYS_RST(rst),
    .iS_AXIS_TVALID(tvalid), .oS_AXIS_TREADY(bTready), .iS_AXIS_TDATA(tdata),
    .iS_AXIS_TKEEP(tkeep), .iS_AXIS_TLAST(tlast),
    .oCOEF_VALID(bValid), .iCOEF_READY(coefReady), .oCOEF_DATA(bData),
    .oCOEF_LAST(bLast), .oCOEF_IDX(bIdx), .oPKT_DONE(bDone),
    .oERR_LEN(bErrLen), .oERR_FMT(bErrFmt), .iERR_CLR(errClr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] idx;
  } coef_t;

  coef_t       expQ[$];
  logic [31:0] logData[$];
  logic        logLast[$];
  logic [15:0] logIdx[$];
  int          logCyc[$];
  int          modelIdx = 0;
  int          emitCount = 0;
  logic        expDone = 1'b0, expErrLen = 1'b0, expErrFmt = 1'b0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;
  logic [15:0] prevIdx;
  logic        started = 1'b0;
  int          readyMode = 0;

  always @(negedge clk) begin : monitor
    coef_t c;
    logic expValid, expReady, newLen, newFmt, twoHalves;
    if (started) begin
      expValid = expQ.size() > 0;
      expReady = !rst && (expQ.size() == 0 || (expQ.size() == 1 && coefReady));
      check("a_valid", 64'(aValid), 64'(expValid));
      check("b_valid", 64'(bValid), 64'(expValid));
      if (expValid) begin
        check("a_data", 64'(aData), 64'(expQ[0].data));
        check("b_data", 64'(bData), 64'(expQ[0].data));
        check("a_last", 64'(aLast), 64'(expQ[0].last));
        check("b_last", 64'(bLast), 64'(expQ[0].last));
        check("a_idx", 64'(aIdx), 64'(expQ[0].idx));
        check("b_idx", 64'(bIdx), 64'(expQ[0].idx));
      end
      check("a_tready", 64'(aTready), 64'(expReady));
      check("b_tready", 64'(bTready), 64'(expReady));
      check("a_pkt_done", 64'(aDone), 64'(expDone));
      check("b_pkt_done", 64'(bDone), 64'(expDone));
      check("a_err_len", 64'(aErrLen), 64'(expErrLen));
      check("a_err_fmt", 64'(aErrFmt), 64'(expErrFmt));
      check("b_err_fmt", 64'(bErrFmt), 64'(expErrFmt));
      if (prevStall) begin
        check("stall_data", 64'(aData), 64'(prevData));
        check("stall_last", 64'(aLast), 64'(prevLast));
        check("stall_idx", 64'(aIdx), 64'(prevIdx));
      end
      if (rst) begin
        expQ.delete();
        modelIdx  = 0;
        emitCount = 0;
        expDone   = 1'b0;
        expErrLen = 1'b0;
        expErrFmt = 1'b0;
        prevStall = 1'b0;
      end else begin
        newLen = expErrLen;
        newFmt = expErrFmt;
        if (errClr) begin
          newLen = 1'b0;
          newFmt = 1'b0;
        end
        expDone   = 1'b0;
        prevStall = expValid && !coefReady;
        prevData  = aData;
        prevLast  = aLast;
        prevIdx   = aIdx;
        if (expValid && coefReady) begin
          c = expQ.pop_front();
          emitCount++;
          logData.push_back(c.data);
          logLast.push_back(c.last);
          logIdx.push_back(c.idx);
          logCyc.push_back(cyc);
          if (c.last) begin
            expDone = 1'b1;
            if (emitCount != NA) newLen = 1'b1;
            emitCount = 0;
          end
        end
        if (tvalid && expReady) begin
          if (tkeep != 8'hFF && tkeep != 8'h0F) newFmt = 1'b1;
          twoHalves = tkeep[7:4] != 4'h0;
          c.data = tdata[31:0];
          c.last = tlast && !twoHalves;
          c.idx  = (modelIdx > 65535) ? 16'hFFFF : 16'(modelIdx);
          expQ.push_back(c);
          modelIdx++;
          if (twoHalves) begin
            c.data = tdata[63:32];
            c.last = tlast;
            c.idx  = (modelIdx > 65535) ? 16'hFFFF : 16'(modelIdx);
            expQ.push_back(c);
            modelIdx++;
          end
          if (tlast) modelIdx = 0;
        end
        expErrLen = newLen;
        expErrFmt = newFmt;
      end
    end
  end

  initial begin
    coefReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0) coefReady = 1'b1;
      else                coefReady = ~coefReady;
    end
  end

  task automatic sendBeat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit hs;
    int n;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = aTready;
      n++;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL beat_accept timeout got=0 want=1 cycle=%0d", cyc);
    end
  endtask

  task automatic sendPacket(input int nBeats, input logic [31:0] loBase, input logic [31:0] hiBase,
                            input logic [31:0] hiStep, input logic [7:0] lastKeep, input int badBeat,
                            input logic [7:0] badKeep, input bit withLast);
    for (int k = 1; k <= nBeats; k++) begin
      logic [7:0]  keep;
      logic [31:0] lo, hi;
      lo   = loBase + 32'(k);
      hi   = hiBase + hiStep * 32'(k);
      keep = (k == badBeat) ? badKeep : ((k == nBeats) ? lastKeep : 8'hFF);
      sendBeat({hi, lo}, keep, withLast && (k == nBeats));
    end
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (aDone) seen = 1'b1;
    end
    check("pkt_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic clearLog();
    logData.delete();
    logLast.delete();
    logIdx.delete();
    logCyc.delete();
  endtask

  task automatic clearErr();
    errClr = 1'b1;
    @(posedge clk); #1;
    errClr = 1'b0;
    #1;
    check("clr_a_err_len", 64'(aErrLen), 64'd0);
    check("clr_b_err_len", 64'(bErrLen), 64'd0);
    check("clr_a_err_fmt", 64'(aErrFmt), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; errClr = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    #1;
    check("rst_valid", 64'(aValid), 64'd0);
    check("rst_tready", 64'(aTready), 64'd0);
    check("rst_done", 64'(aDone), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_tready", 64'(aTready), 64'd1);
    check("post_rst_idx", 64'(aIdx), 64'd0);
    check("post_rst_err_len", 64'(aErrLen), 64'd0);
    check("post_rst_err_fmt", 64'(aErrFmt), 64'd0);
    @(posedge clk); #1;

    // ten full beats, low half k, high half 0
    clearLog();
    sendPacket(10, 32'h0, 32'h0, 32'h0, 8'hFF, 0, 8'hFF, 1'b1);
    waitDone();
    check("p1_count", 64'(logData.size()), 64'd20);
    check("p1_d0", 64'(logData[0]), 64'd1);
    check("p1_d1", 64'(logData[1]), 64'd0);
    check("p1_d2", 64'(logData[2]), 64'd2);
    check("p1_d18", 64'(logData[18]), 64'd10);
    check("p1_d19", 64'(logData[19]), 64'd0);
    check("p1_idx19", 64'(logIdx[19]), 64'd19);
    check("p1_last18", 64'(logLast[18]), 64'd0);
    check("p1_last19", 64'(logLast[19]), 64'd1);
    check("p1_b2b", 64'(logCyc[19] - logCyc[0]), 64'd19);
    check("p1_a_err_len", 64'(aErrLen), 64'd0);
    check("p1_b_err_len", 64'(bErrLen), 64'd1);
    @(posedge clk); #1;
    clearErr();

    // last beat carries only its lower half
    clearLog();
    sendPacket(10, 32'h100, 32'h200, 32'h1, 8'h0F, 0, 8'hFF, 1'b1);
    waitDone();
    check("p2_count", 64'(logData.size()), 64'd19);
    check("p2_d18", 64'(logData[18]), 64'h10A);
    check("p2_last18", 64'(logLast[18]), 64'd1);
    check("p2_idx18", 64'(logIdx[18]), 64'd18);
    check("p2_a_err_len", 64'(aErrLen), 64'd1);
    check("p2_b_err_len", 64'(bErrLen), 64'd0);
    @(posedge clk); #1;
    clearErr();

    // downstream ready toggling every cycle
    clearLog();
    readyMode = 1;
    sendPacket(10, 32'h1000, 32'h2000, 32'h1, 8'hFF, 0, 8'hFF, 1'b1);
    waitDone();
    check("p3_count", 64'(logData.size()), 64'd20);
    check("p3_d1", 64'(logData[1]), 64'h2001);
    check("p3_d19", 64'(logData[19]), 64'h200A);
    check("p3_a_err_len", 64'(aErrLen), 64'd0);
    @(posedge clk); #1;
    readyMode = 0;
    repeat (2) @(posedge clk);
    #1;

    // malformed keep on beat 3 still yields two coefficients
    clearLog();
    sendPacket(10, 32'h3000, 32'h4000, 32'h1, 8'hFF, 3, 8'h3F, 1'b1);
    waitDone();
    check("p4_err_fmt", 64'(aErrFmt), 64'd1);
    check("p4_count", 64'(logData.size()), 64'd20);
    check("p4_d5", 64'(logData[5]), 64'h4003);
    check("p4_a_err_len", 64'(aErrLen), 64'd0);
    @(posedge clk); #1;
    clearErr();

    // reset while the upper half of beat 5 is on the output
    clearLog();
    sendPacket(5, 32'h5000, 32'h6000, 32'h1, 8'hFF, 0, 8'hFF, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(posedge clk); #3;
      if (aValid && aIdx == 16'd9) found = 1'b1;
    end
    check("p5_reached_hi5", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("p5_valid", 64'(aValid), 64'd0);
    check("p5_tready", 64'(aTready), 64'd1);
    check("p5_idx", 64'(aIdx), 64'd0);
    @(posedge clk); #1;

    clearLog();
    sendPacket(10, 32'h7000, 32'h8000, 32'h1, 8'hFF, 0, 8'hFF, 1'b1);
    waitDone();
    check("p6_count", 64'(logData.size()), 64'd20);
    check("p6_d0", 64'(logData[0]), 64'h7001);
    check("p6_idx0", 64'(logIdx[0]), 64'd0);
    check("p6_a_err_len", 64'(aErrLen), 64'd0);
    check("p6_a_err_fmt", 64'(aErrFmt), 64'd0);

    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
